proc_seq: RTL and testbench

- Program sequencer for the 9-bit multi-cycle processor (mv/mvi/add/sub, IR format III XXX YYY).
- Fetches instruction words from a synchronous-read program memory and presents them on the processor's DIN with a one-cycle Run pulse.
- Supplies the mvi immediate on DIN in the following cycle, waits for Done, then advances the PC.
- Sits between program ROM/RAM and the processor; provides run, single-step and halt control to the board.

---
 rtl/proc_seq.sv | 191 +++++++++++++++++++
 tb/tb_proc_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_seq.sv
// Program sequencer for the 9-bit mv/mvi/add/sub processor (IR = III XXX YYY): fetches from a
// synchronous-read program memory, issues with a one-cycle Run, feeds the mvi immediate, waits for Done.
// Define PROC_SEQ_WATCHDOG_EN to fault to ERR after WD_LIMIT consecutive WAIT cycles without Done.

module proc_seq #(
  parameter int AW       = 5,
  parameter int WD_LIMIT = 7
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Go,
  input  logic          Step,
  input  logic          Halt,
  input  logic          PcClr,
  output logic [AW-1:0] MemAddr,
  input  logic [8:0]    MemData,
  output logic [8:0]    DIN,
  output logic          Run,
  input  logic          Done,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Err,
  output logic [7:0]    InstrCnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FI,
    S_FD,
    S_FM,
    S_ISSUE,
    S_WAIT,
    S_ERR
  } state_t;

  localparam logic [2:0] OP_MVI = 3'b001;

  if (WD_LIMIT < 1) begin : g_bad_wd_limit
    $error("proc_seq: WD_LIMIT must be at least 1");
  end

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_addr_hold;
  logic [8:0]    r_ir;
  logic [8:0]    r_imm;
  logic [8:0]    r_din;
  logic          r_run;
  logic          r_halt_req;
  logic          r_step_mode;
  logic [7:0]    r_cnt;

`ifdef PROC_SEQ_WATCHDOG_EN
  localparam int WDW = (WD_LIMIT > 1) ? $clog2(WD_LIMIT) : 1;
  logic [WDW-1:0] r_wd;
`endif

  logic          w_busy;
  logic          w_fd_mvi;
  logic          w_fd_bad;
  logic          w_ir_mvi;
  logic [AW-1:0] w_pc_plus1;
  logic [AW-1:0] w_pc_next;
  logic [AW-1:0] w_mem_addr;

  assign w_busy     = (r_state != S_IDLE) && (r_state != S_ERR);
  assign w_fd_mvi   = (MemData[8:6] == OP_MVI);
  assign w_fd_bad   = MemData[8];
  assign w_ir_mvi   = (r_ir[8:6] == OP_MVI);
  assign w_pc_plus1 = r_pc + AW'(1);
  assign w_pc_next  = r_pc + (w_ir_mvi ? AW'(2) : AW'(1));

  // The memory registers its address, so the address must be valid during FI/FD themselves;
  // in FD the mvi decision comes straight from MemData, hence a combinational mux plus a hold register.
  always_comb begin
    // NOTE: default assignment first so every path drives w_mem_addr and no latch is inferred.
    w_mem_addr = r_addr_hold;
    case (r_state)
      S_FI:    w_mem_addr = r_pc;
      S_FD:    if (w_fd_mvi) w_mem_addr = w_pc_plus1;
      default: ;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_addr_hold <= '0;
      r_ir        <= '0;
      r_imm       <= '0;
      r_din       <= '0;
      r_run       <= 1'b0;
      r_halt_req  <= 1'b0;
      r_step_mode <= 1'b0;
      r_cnt       <= '0;
`ifdef PROC_SEQ_WATCHDOG_EN
      r_wd        <= '0;
`endif
    end else begin
      r_addr_hold <= w_mem_addr;
      r_run       <= 1'b0;
      if (Halt && w_busy) r_halt_req <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (PcClr) begin
            r_pc  <= '0;
            r_cnt <= '0;
          end else if (Step || Go) begin
            r_step_mode <= Step;
            r_state     <= S_FI;
          end
        end

        S_FI: r_state <= S_FD;

        S_FD: begin
          r_ir <= MemData;
          if (w_fd_bad) begin
            r_state <= S_ERR;
          end else if (w_fd_mvi) begin
            r_state <= S_FM;
          end else begin
            r_din   <= MemData;
            r_run   <= 1'b1;
            r_state <= S_ISSUE;
          end
        end

        S_FM: begin
          r_imm   <= MemData;
          r_din   <= r_ir;
          r_run   <= 1'b1;
          r_state <= S_ISSUE;
        end

        S_ISSUE: begin
          r_din   <= w_ir_mvi ? r_imm : r_ir;
          r_state <= S_WAIT;
`ifdef PROC_SEQ_WATCHDOG_EN
          r_wd    <= '0;
`endif
        end

        S_WAIT: begin
          if (Done) begin
            r_pc  <= w_pc_next;
            r_cnt <= r_cnt + 8'd1;
            if (r_halt_req || Halt || r_step_mode) begin
              r_halt_req  <= 1'b0;
              r_step_mode <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_state <= S_FI;
            end
          end
`ifdef PROC_SEQ_WATCHDOG_EN
          else if (r_wd == WDW'(WD_LIMIT - 1)) begin
            r_state <= S_ERR;
          end else begin
            r_wd <= r_wd + WDW'(1);
          end
`endif
        end

        S_ERR: begin
          if (PcClr) begin
            r_pc        <= '0;
            r_cnt       <= '0;
            r_halt_req  <= 1'b0;
            r_step_mode <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign MemAddr  = w_mem_addr;
  assign DIN      = r_din;
  assign Run      = r_run;
  assign PC       = r_pc;
  assign Busy     = w_busy;
  assign Err      = (r_state == S_ERR);
  assign InstrCnt = r_cnt;

endmodule

// File: tb/tb_proc_seq.sv
// Bench for proc_seq: program memory, a behavioural processor (mv/mvi/add/sub) and a
// retire-level model of PC / InstrCnt / issued words checked every cycle, plus directed scenarios.

module tb_proc_seq;

  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          Clock = 1'b0;
  logic          Resetn, Go, Step, Halt, PcClr;
  logic [AW-1:0] MemAddr;
  logic [8:0]    MemData;
  logic [8:0]    DIN;
  logic          Run, Done;
  logic [AW-1:0] PC;
  logic          Busy, Err;
  logic [7:0]    InstrCnt;

  proc_seq #(.AW(AW), .WD_LIMIT(7)) dut (
    .Clock(Clock), .Resetn(Resetn), .Go(Go), .Step(Step), .Halt(Halt), .PcClr(PcClr),
    .MemAddr(MemAddr), .MemData(MemData), .DIN(DIN), .Run(Run), .Done(Done),
    .PC(PC), .Busy(Busy), .Err(Err), .InstrCnt(InstrCnt)
  );

  always #5 Clock = ~Clock;

  // Synchronous-read program memory
  logic [8:0] mem [DEPTH];
  always @(posedge Clock) MemData <= mem[MemAddr];

  // Behavioural processor: mv/mvi finish in T1, add/sub in T3
  logic [8:0] R [8];
  logic [8:0] p_ir, p_a, p_g;
  logic [1:0] p_t;
  logic       done_block, done_inject;
  wire        p_done = (p_t == 2'd1 && p_ir[8:7] == 2'b00) || (p_t == 2'd3);
  assign Done = (p_done & ~done_block) | done_inject;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      p_t  <= 2'd0;
      p_ir <= '0;
      p_a  <= '0;
      p_g  <= '0;
      for (int i = 0; i < 8; i++) R[i] <= '0;
    end else begin
      case (p_t)
        2'd0: if (Run) begin p_ir <= DIN; p_t <= 2'd1; end
        2'd1: begin
          case (p_ir[8:6])
            3'b000:  begin R[p_ir[5:3]] <= R[p_ir[2:0]]; p_t <= 2'd0; end
            3'b001:  begin R[p_ir[5:3]] <= DIN;          p_t <= 2'd0; end
            default: begin p_a <= R[p_ir[5:3]];          p_t <= 2'd2; end
          endcase
        end
        2'd2: begin
          p_g <= (p_ir[8:6] == 3'b011) ? p_a - R[p_ir[2:0]] : p_a + R[p_ir[2:0]];
          p_t <= 2'd3;
        end
        default: begin R[p_ir[5:3]] <= p_g; p_t <= 2'd0; end
      endcase
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Edge-sampled inputs seen by the model
  logic e_done, e_clr;
  always @(posedge Clock) begin
    e_done <= Done;
    e_clr  <= PcClr;
  end

  // Retire-level model: PC/InstrCnt change only when an issued instruction sees Done
  int m_pc, m_cnt, run_cnt, cyc;
  bit m_pending, m_is_mvi, m_prev_mvi;
  int retire_cyc[$];

  task monitor();
    forever begin
      @(negedge Clock);
      cyc++;
      if (!Resetn) begin
        m_pc = 0; m_cnt = 0; m_pending = 0; m_prev_mvi = 0;
      end else begin
        if (e_done && m_pending) begin
          m_pc      = (m_pc + (m_is_mvi ? 2 : 1)) % DEPTH;
          m_cnt     = (m_cnt + 1) % 256;
          m_pending = 0;
          retire_cyc.push_back(cyc);
        end
        if (e_clr && !m_pending) begin
          m_pc = 0; m_cnt = 0;
        end
        check("pc", PC, m_pc);
        check("instr_cnt", InstrCnt, m_cnt);
        if (m_prev_mvi) check("din_imm", DIN, mem[(m_pc + 1) % DEPTH]);
        m_prev_mvi = 0;
        if (Run) begin
          check("run_overlap", m_pending, 0);
          check("din_instr", DIN, mem[m_pc]);
          m_pending  = 1;
          m_is_mvi   = (mem[m_pc][8:6] == 3'b001);
          m_prev_mvi = m_is_mvi;
          run_cnt++;
        end
      end
    end
  endtask

  // Step just past the falling edge so the monitor has already processed it
  task tick(input int n);
    repeat (n) begin
      @(negedge Clock);
      #1;
    end
  endtask

  task wait_idle(input string nm, input int bound);
    int k;
    k = 0;
    while (Busy && k < bound) begin tick(1); k++; end
    check(nm, Busy, 0);
  endtask

  task wait_runs(input string nm, input int target, input int bound);
    int k;
    k = 0;
    while (run_cnt < target && k < bound) begin tick(1); k++; end
    check(nm, run_cnt, target);
  endtask

  task pulse_clr();
    PcClr = 1'b1; tick(1); PcClr = 1'b0; tick(1);
  endtask

  task do_step(input string nm);
    int r0;
    r0 = run_cnt;
    Step = 1'b1; tick(1); Step = 1'b0;
    check("busy_on_step", Busy, 1);
    wait_idle("step_idle_timeout", 20);
    check(nm, run_cnt - r0, 1);
  endtask

  int r_base, k;

  initial begin
    Resetn = 1'b0; Go = 1'b0; Step = 1'b0; Halt = 1'b0; PcClr = 1'b0;
    done_block = 1'b0; done_inject = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[0] = 9'b001000000;  // mvi R0
    mem[1] = 9'd5;
    mem[2] = 9'b001001000;  // mvi R1
    mem[3] = 9'd3;
    mem[4] = 9'b010000001;  // add R0,R1
    fork monitor(); join_none
    tick(2);
    check("rst_run", Run, 0);
    check("rst_din", DIN, 0);
    check("rst_memaddr", MemAddr, 0);
    check("rst_pc", PC, 0);
    check("rst_busy", Busy, 0);
    check("rst_err", Err, 0);
    check("rst_cnt", InstrCnt, 0);
    Resetn = 1'b1;
    tick(1);

    // Free run, halt while the add waits
    Go = 1'b1;
    wait_runs("go_add_issue", 3, 40);
    Go = 1'b0; Halt = 1'b1; tick(1); Halt = 1'b0;
    wait_idle("halt_idle_timeout", 20);
    check("go_pc", PC, 5);
    check("go_cnt", InstrCnt, 3);
    check("go_r0", R[0], 8);
    check("model_pc", m_pc, 5);
    check("retire_count", retire_cyc.size(), 3);
    if (retire_cyc.size() == 3) begin
      check("mvi_cycles", retire_cyc[1] - retire_cyc[0], 5);
      check("add_cycles", retire_cyc[2] - retire_cyc[1], 6);
    end
    tick(8);
    check("no_run_after_halt", run_cnt, 3);

    // Done outside WAIT is ignored
    done_inject = 1'b1; tick(1); done_inject = 1'b0; tick(2);
    check("stray_done_pc", PC, 5);
    check("stray_done_cnt", InstrCnt, 3);

    // Single-step the same program
    pulse_clr();
    check("clr_pc", PC, 0);
    check("clr_cnt", InstrCnt, 0);
    do_step("step1_one_run");
    do_step("step2_one_run");
    check("step_pc4", PC, 4);
    do_step("step_add_one_run");
    check("step_pc5", PC, 5);
    check("step_cnt", InstrCnt, 3);
    check("step_r0", R[0], 8);
    check("step_busy", Busy, 0);

    // Illegal opcode at PC 2
    pulse_clr();
    mem[0] = 9'b000010000;  // mv R2,R0
    mem[1] = 9'b000011001;  // mv R3,R1
    mem[2] = 9'b100000000;
    r_base = run_cnt;
    Go = 1'b1;
    k = 0;
    while (!Err && k < 40) begin tick(1); k++; end
    check("err_set", Err, 1);
    if (retire_cyc.size() > 0) check("err_latency", cyc - retire_cyc[retire_cyc.size() - 1], 2);
    tick(3);
    Go = 1'b0;
    check("err_sticky", Err, 1);
    check("err_busy", Busy, 0);
    check("err_run", Run, 0);
    check("err_pc", PC, 2);
    check("err_cnt", InstrCnt, 2);
    check("err_runs", run_cnt - r_base, 2);
    check("mv_r2", R[2], 8);
    if (retire_cyc.size() >= 2)
      check("mv_cycles", retire_cyc[retire_cyc.size() - 1] - retire_cyc[retire_cyc.size() - 2], 4);
    pulse_clr();
    check("errclr_err", Err, 0);
    check("errclr_pc", PC, 0);
    check("errclr_cnt", InstrCnt, 0);
    check("errclr_busy", Busy, 0);

    // mvi at 31 reads its immediate from address 0; Halt in IDLE must not linger
    mem[0] = 9'b000000111;  // mv R0,R7
    for (int i = 1; i < 31; i++) mem[i] = 9'b000001001;
    mem[31] = 9'b001101000;  // mvi R5
    Halt = 1'b1; tick(1); Halt = 1'b0;
    r_base = run_cnt;
    Go = 1'b1;
    wait_runs("wrap_mvi_issue", r_base + 32, 200);
    check("wrap_memaddr", MemAddr, 0);
    check("wrap_din", DIN, 9'b001101000);
    Go = 1'b0; Halt = 1'b1; tick(1); Halt = 1'b0;
    wait_idle("wrap_idle_timeout", 20);
    check("wrap_pc", PC, 1);
    check("wrap_cnt", InstrCnt, 32);
    check("wrap_r5", R[5], 7);

    // Done never arrives
    pulse_clr();
    done_block = 1'b1;
    r_base = run_cnt;
    Step = 1'b1; tick(1); Step = 1'b0;
    wait_runs("wd_issue", r_base + 1, 10);
    tick(7);
    check("wd_wait7_err", Err, 0);
    check("wd_wait7_busy", Busy, 1);
`ifdef PROC_SEQ_WATCHDOG_EN
    tick(1);
    check("wd_err", Err, 1);
    check("wd_busy", Busy, 0);
    check("wd_cnt", InstrCnt, 0);
    check("wd_pc", PC, 0);
`else
    tick(20);
    check("nowd_busy", Busy, 1);
    check("nowd_err", Err, 0);
    check("nowd_cnt", InstrCnt, 0);
`endif

    // Asynchronous reset aborts
    Resetn = 1'b0;
    #2;
    check("abort_busy", Busy, 0);
    check("abort_err", Err, 0);
    check("abort_run", Run, 0);
    tick(1);
    done_block = 1'b0;
    Resetn = 1'b1;
    tick(2);
    check("post_rst_pc", PC, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
